// File: rtl/ftdi_link_sequencer.sv
// rtl/ftdi_link_sequencer.sv - transmit/receive scheduler for an FTDI FIFO link
//
// Purpose: alternates the FTDI interface between draining one staged transmit
// packet and a bounded receive slot. A drain that stops seeing write strobes
// is aborted and flagged as a sticky error.
//
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   tx_enable/rx_enable scheduling permissions for each direction
//   tx_pkt_ready        a complete packet is waiting in the packet queue
//   wrq_empty/rdq_full  FTDI interface queue flags
//   wr_strobe           one pulse per byte written to the FTDI chip
//   err_clr             clears timeout_err
//   load_1k             one-cycle pulse that starts packet staging
//   wr_en/rd_en         mutually exclusive write/read permissions
//   clear               one-cycle abort pulse
//   pkt_done            one-cycle pulse on the last byte of a packet
//   timeout_err         sticky drain-stall error
//   pkts_sent           completed packet count (wraps)
//   state               current FSM state, for debug
module ftdi_link_sequencer #(
    parameter int unsigned PKT_BYTES      = 1024,
    parameter int unsigned SLOT_CYCLES    = 256,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        tx_enable,
    input  logic        rx_enable,
    input  logic        tx_pkt_ready,
    input  logic        wrq_empty,
    input  logic        rdq_full,
    input  logic        wr_strobe,
    input  logic        err_clr,
    output logic        load_1k,
    output logic        wr_en,
    output logic        rd_en,
    output logic        clear,
    output logic        pkt_done,
    output logic        timeout_err,
    output logic [15:0] pkts_sent,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_DRAIN   = 3'd2,
        S_RX_SLOT = 3'd3,
        S_ABORT   = 3'd4
    } state_t;

    localparam logic [10:0] LAST_BYTE  = 11'(PKT_BYTES - 1);
    localparam logic [15:0] SLOT_LAST  = 16'(SLOT_CYCLES - 1);
    localparam logic [15:0] STALL_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [10:0] byte_cnt_q, byte_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] slot_cnt_q, slot_cnt_d;
    logic [15:0] pkts_sent_q, pkts_sent_d;
    logic        timeout_err_q, timeout_err_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            byte_cnt_q    <= '0;
            stall_cnt_q   <= '0;
            slot_cnt_q    <= '0;
            pkts_sent_q   <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            byte_cnt_q    <= byte_cnt_d;
            stall_cnt_q   <= stall_cnt_d;
            slot_cnt_q    <= slot_cnt_d;
            pkts_sent_q   <= pkts_sent_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        byte_cnt_d    = byte_cnt_q;
        stall_cnt_d   = stall_cnt_q;
        // The slot counter only runs inside RX_SLOT, so it always starts at 0.
        slot_cnt_d    = '0;
        pkts_sent_d   = pkts_sent_q;
        // An ABORT set below overrides a simultaneous clear request.
        timeout_err_d = timeout_err_q & ~err_clr;
        load_1k       = 1'b0;
        wr_en         = 1'b0;
        rd_en         = 1'b0;
        clear         = 1'b0;
        pkt_done      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                rd_en = rx_enable & ~rdq_full;
                if (tx_enable && tx_pkt_ready && !wrq_empty) begin
                    state_d = S_LOAD;
                end
            end

            S_LOAD: begin
                load_1k     = 1'b1;
                byte_cnt_d  = '0;
                stall_cnt_d = '0;
                state_d     = S_DRAIN;
            end

            S_DRAIN: begin
                wr_en = 1'b1;
                // A strobe excludes a stall, so completion always wins over timeout.
                if (wr_strobe) begin
                    stall_cnt_d = '0;
                    if (byte_cnt_q == LAST_BYTE) begin
                        pkt_done    = 1'b1;
                        pkts_sent_d = pkts_sent_q + 16'd1;
                        byte_cnt_d  = '0;
                        state_d     = rx_enable ? S_RX_SLOT : S_IDLE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 11'd1;
                    end
                end else if (stall_cnt_q == STALL_LAST) begin
                    stall_cnt_d = '0;
                    state_d     = S_ABORT;
                end else begin
                    stall_cnt_d = stall_cnt_q + 16'd1;
                end
            end

            S_RX_SLOT: begin
                rd_en = ~rdq_full;
                if (!rx_enable || slot_cnt_q == SLOT_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    slot_cnt_d = slot_cnt_q + 16'd1;
                end
            end

            S_ABORT: begin
                clear         = 1'b1;
                timeout_err_d = 1'b1;
                byte_cnt_d    = '0;
                stall_cnt_d   = '0;
                state_d       = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Reset forces IDLE asynchronously, but IDLE's read grant is
        // combinational and must not leak out while reset is held.
        if (reset) begin
            rd_en = 1'b0;
        end
    end

    assign pkts_sent   = pkts_sent_q;
    assign timeout_err = timeout_err_q;
    assign state       = state_q;

endmodule

// File: tb/tb_ftdi_link_sequencer.sv
// tb/tb_ftdi_link_sequencer.sv - self-checking bench for ftdi_link_sequencer
`timescale 1ns/1ps
module tb_ftdi_link_sequencer;

    localparam int S_P = 3, S_SLOT = 5, S_TO = 4;
    localparam int B_P = 1024, B_SLOT = 256, B_TO = 100;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;

    // Small instance: table vectors and randomized run against the model.
    logic s_reset, s_tx, s_rx, s_rdy, s_empty, s_full, s_strobe, s_clr;
    logic s_load, s_wr, s_rd, s_clear, s_done, s_err;
    logic [15:0] s_sent;
    logic [2:0]  s_state;

    // Default-sized instance: long hand-written sequences.
    logic b_reset, b_tx, b_rx, b_rdy, b_empty, b_full, b_strobe, b_clr;
    logic b_load, b_wr, b_rd, b_clear, b_done, b_err;
    logic [15:0] b_sent;
    logic [2:0]  b_state;

    ftdi_link_sequencer #(.PKT_BYTES(S_P), .SLOT_CYCLES(S_SLOT), .TIMEOUT_CYCLES(S_TO)) u_small (
        .clock(clock), .reset(s_reset), .tx_enable(s_tx), .rx_enable(s_rx),
        .tx_pkt_ready(s_rdy), .wrq_empty(s_empty), .rdq_full(s_full),
        .wr_strobe(s_strobe), .err_clr(s_clr), .load_1k(s_load), .wr_en(s_wr),
        .rd_en(s_rd), .clear(s_clear), .pkt_done(s_done), .timeout_err(s_err),
        .pkts_sent(s_sent), .state(s_state)
    );

    ftdi_link_sequencer #(.PKT_BYTES(B_P), .SLOT_CYCLES(B_SLOT), .TIMEOUT_CYCLES(B_TO)) u_big (
        .clock(clock), .reset(b_reset), .tx_enable(b_tx), .rx_enable(b_rx),
        .tx_pkt_ready(b_rdy), .wrq_empty(b_empty), .rdq_full(b_full),
        .wr_strobe(b_strobe), .err_clr(b_clr), .load_1k(b_load), .wr_en(b_wr),
        .rd_en(b_rd), .clear(b_clear), .pkt_done(b_done), .timeout_err(b_err),
        .pkts_sent(b_sent), .state(b_state)
    );

    typedef struct {
        logic tx, rx, rdy, empty, full, strobe, clr;
        logic [2:0]  st;
        logic [5:0]  outs;   // {load_1k, wr_en, rd_en, clear, pkt_done, timeout_err}
        logic [15:0] sent;
    } vec_t;

    vec_t tbl[22];

    function automatic vec_t mk(input logic [6:0] i, input logic [2:0] st,
                                input logic [5:0] o, input logic [15:0] sent);
        vec_t v;
        v.tx = i[6]; v.rx = i[5]; v.rdy = i[4]; v.empty = i[3];
        v.full = i[2]; v.strobe = i[1]; v.clr = i[0];
        v.st = st; v.outs = o; v.sent = sent;
        return v;
    endfunction

    task automatic cmp_small(input string tag, input logic [2:0] st,
                             input logic [5:0] o, input logic [15:0] sent);
        logic [5:0] act;
        act = {s_load, s_wr, s_rd, s_clear, s_done, s_err};
        vectors++;
        if (s_state !== st || act !== o || s_sent !== sent || (s_wr && s_rd)) begin
            miscompares++;
            $display("FAIL %s @%0t: got state=%0d outs=%b sent=%0d, expected state=%0d outs=%b sent=%0d",
                     tag, $time, s_state, act, s_sent, st, o, sent);
        end
    endtask

    task automatic check(input string tag, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Reference model for the small instance: phase, bytes strobed, quiet run
    // length, cycles spent receiving, error flag and packet total.
    int m_phase, m_bytes, m_quiet, m_slot, m_sent;
    bit m_err;

    task automatic model_reset();
        m_phase = 0; m_bytes = 0; m_quiet = 0; m_slot = 0; m_sent = 0; m_err = 0;
    endtask

    task automatic model_outputs(output logic [2:0] st, output logic [5:0] o, output logic [15:0] sent);
        logic ld, wr, rd, cl, dn;
        if (s_reset) begin
            st = 3'd0; o = 6'd0; sent = 16'd0;
        end else begin
            ld = (m_phase == 1);
            wr = (m_phase == 2);
            rd = (m_phase == 0 && s_rx && !s_full) || (m_phase == 3 && !s_full);
            cl = (m_phase == 4);
            dn = (m_phase == 2) && s_strobe && (m_bytes + 1 == S_P);
            st = 3'(m_phase);
            o = {ld, wr, rd, cl, dn, m_err};
            sent = 16'(m_sent);
        end
    endtask

    task automatic model_step();
        int prev;
        if (s_reset) begin
            model_reset();
            return;
        end
        prev = m_phase;
        case (m_phase)
            0: if (s_tx && s_rdy && !s_empty) m_phase = 1;
            1: begin m_bytes = 0; m_quiet = 0; m_phase = 2; end
            2: begin
                if (s_strobe) begin
                    m_bytes++;
                    m_quiet = 0;
                    if (m_bytes == S_P) begin
                        m_sent = (m_sent + 1) % 65536;
                        m_bytes = 0;
                        m_slot = 0;
                        m_phase = s_rx ? 3 : 0;
                    end
                end else begin
                    m_quiet++;
                    if (m_quiet == S_TO) m_phase = 4;
                end
            end
            3: begin
                m_slot++;
                if (!s_rx || m_slot == S_SLOT) m_phase = 0;
            end
            default: m_phase = 0;
        endcase
        if (prev == 4) m_err = 1;
        else if (s_clr) m_err = 0;
    endtask

    // Pulse counters and exclusivity watch on the default-sized instance.
    int b_clear_cnt = 0, b_done_cnt = 0, b_load_cnt = 0;
    always @(negedge clock) begin
        b_clear_cnt += int'(b_clear);
        b_done_cnt  += int'(b_done);
        b_load_cnt  += int'(b_load);
        if (b_wr && b_rd) begin
            miscompares++;
            $display("FAIL big_wr_rd_excl @%0t: got wr_en=1 rd_en=1 expected not both", $time);
        end
    end

    task automatic b_drain(input int n, output int done_n, output int done_at, output int wr_low);
        done_n = 0; done_at = 0; wr_low = 0;
        for (int i = 1; i <= n; i++) begin
            b_strobe = 1'b1;
            @(negedge clock);
            if (b_done) begin done_n++; done_at = i; end
            if (!b_wr) wr_low++;
            @(posedge clock); #1;
        end
        b_strobe = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  est;
        logic [5:0]  eo;
        logic [15:0] esent;
        int dn, dat, wlow, cnt, bad, c0, d0, l0;

        // tx rx rdy empty full strobe clr | state | load wr rd clear done err | sent
        tbl[0]  = mk(7'b0110000, 3'd0, 6'b001000, 16'd0);
        tbl[1]  = mk(7'b0110100, 3'd0, 6'b000000, 16'd0);
        tbl[2]  = mk(7'b1010010, 3'd0, 6'b000000, 16'd0);
        tbl[3]  = mk(7'b0110010, 3'd1, 6'b100000, 16'd0);
        tbl[4]  = mk(7'b0110010, 3'd2, 6'b010000, 16'd0);
        tbl[5]  = mk(7'b0110000, 3'd2, 6'b010000, 16'd0);
        tbl[6]  = mk(7'b0110010, 3'd2, 6'b010000, 16'd0);
        tbl[7]  = mk(7'b0110010, 3'd2, 6'b010010, 16'd0);
        tbl[8]  = mk(7'b1110000, 3'd3, 6'b001000, 16'd1);
        tbl[9]  = mk(7'b1110100, 3'd3, 6'b000000, 16'd1);
        tbl[10] = mk(7'b1010000, 3'd3, 6'b001000, 16'd1);
        tbl[11] = mk(7'b1011000, 3'd0, 6'b000000, 16'd1);
        tbl[12] = mk(7'b1010000, 3'd0, 6'b000000, 16'd1);
        tbl[13] = mk(7'b0010000, 3'd1, 6'b100000, 16'd1);
        tbl[14] = mk(7'b0010000, 3'd2, 6'b010000, 16'd1);
        tbl[15] = mk(7'b0010000, 3'd2, 6'b010000, 16'd1);
        tbl[16] = mk(7'b0010000, 3'd2, 6'b010000, 16'd1);
        tbl[17] = mk(7'b0010000, 3'd2, 6'b010000, 16'd1);
        tbl[18] = mk(7'b0010001, 3'd4, 6'b000100, 16'd1);
        tbl[19] = mk(7'b0010000, 3'd0, 6'b000001, 16'd1);
        tbl[20] = mk(7'b0010001, 3'd0, 6'b000001, 16'd1);
        tbl[21] = mk(7'b0010000, 3'd0, 6'b000000, 16'd1);

        {s_tx, s_rdy, s_empty, s_full, s_strobe, s_clr} = '0;
        {b_tx, b_rx, b_rdy, b_empty, b_full, b_strobe, b_clr} = '0;
        s_rx = 1'b1;
        s_reset = 1'b1;
        b_reset = 1'b1;
        repeat (2) begin @(posedge clock); #1; end
        @(negedge clock);
        cmp_small("reset_state", 3'd0, 6'b000000, 16'd0);
        @(posedge clock); #1;
        s_reset = 1'b0;

        foreach (tbl[i]) begin
            {s_tx, s_rx, s_rdy, s_empty, s_full, s_strobe, s_clr} =
                {tbl[i].tx, tbl[i].rx, tbl[i].rdy, tbl[i].empty, tbl[i].full, tbl[i].strobe, tbl[i].clr};
            @(negedge clock);
            cmp_small($sformatf("table_row%0d", i), tbl[i].st, tbl[i].outs, tbl[i].sent);
            @(posedge clock); #1;
        end

        s_reset = 1'b1;
        @(posedge clock); #1;
        s_reset = 1'b0;
        model_reset();
        for (int i = 0; i < 10000; i++) begin
            int p;
            case ((i / 250) % 3)
                0: p = 5;
                1: p = 40;
                default: p = 90;
            endcase
            s_reset  = ($urandom_range(0, 499) == 0);
            s_tx     = ($urandom_range(0, 99) < 80);
            s_rx     = ($urandom_range(0, 99) < 60);
            s_rdy    = ($urandom_range(0, 99) < 80);
            s_empty  = ($urandom_range(0, 99) < 15);
            s_full   = ($urandom_range(0, 99) < 30);
            s_strobe = ($urandom_range(0, 99) < p);
            s_clr    = ($urandom_range(0, 99) < 5);
            model_outputs(est, eo, esent);
            @(negedge clock);
            cmp_small("random", est, eo, esent);
            @(posedge clock);
            model_step();
            #1;
        end
        s_reset = 1'b1;

        // Reset state of the default-sized instance, with rx_enable requesting reads.
        b_rx = 1'b1;
        @(negedge clock);
        check("big_reset_outputs",
              int'({b_state, b_load, b_wr, b_rd, b_clear, b_done, b_err, b_sent}), 0);
        @(posedge clock); #1;
        b_reset = 1'b0;
        b_rx = 1'b0; b_tx = 1'b1; b_rdy = 1'b1; b_empty = 1'b0;

        // One packet with receive disabled; tx_enable drops during the packet.
        @(negedge clock);
        check("pkt1_idle_state", int'(b_state), 0);
        l0 = b_load_cnt;
        @(posedge clock); #1;
        @(negedge clock);
        check("pkt1_load_pulse", int'({b_state, b_load, b_wr, b_rd}), int'({3'd1, 3'b100}));
        b_tx = 1'b0;
        @(posedge clock); #1;
        b_drain(B_P, dn, dat, wlow);
        check("pkt1_done_count", dn, 1);
        check("pkt1_done_on_last_strobe", dat, B_P);
        check("pkt1_wr_en_held", wlow, 0);
        @(negedge clock);
        check("pkt1_back_to_idle", int'(b_state), 0);
        check("pkt1_pkts_sent", int'(b_sent), 1);
        check("pkt1_single_load_pulse", b_load_cnt - l0, 1);

        // Packet followed by a receive slot, with a transmit pending throughout.
        b_rx = 1'b1; b_tx = 1'b1;
        @(posedge clock); #1;
        b_tx = 1'b0;
        @(posedge clock); #1;
        b_drain(B_P, dn, dat, wlow);
        check("pkt2_done_on_last_strobe", dat, B_P);
        b_tx = 1'b1;
        cnt = 0; bad = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clock);
            if (b_state != 3'd3) break;
            cnt++;
            if (!b_rd || b_wr) bad++;
            @(posedge clock); #1;
        end
        check("rx_slot_length", cnt, B_SLOT);
        check("rx_slot_rd_only", bad, 0);
        check("rx_slot_exit_idle", int'(b_state), 0);
        check("pkt2_pkts_sent", int'(b_sent), 2);

        // Drain that never strobes: timeout abort.
        b_rx = 1'b0;
        c0 = b_clear_cnt; d0 = b_done_cnt;
        @(posedge clock); #1;
        b_tx = 1'b0;
        @(posedge clock); #1;
        cnt = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (b_state != 3'd2) break;
            cnt++;
            @(posedge clock); #1;
        end
        check("stall_cycles_before_abort", cnt, B_TO);
        check("abort_state_outputs", int'({b_state, b_wr, b_rd, b_clear}), int'({3'd4, 3'b001}));
        repeat (3) begin @(posedge clock); #1; end
        @(negedge clock);
        check("abort_clear_once", b_clear_cnt - c0, 1);
        check("abort_no_pkt_done", b_done_cnt - d0, 0);
        check("abort_err_set", int'(b_err), 1);
        check("abort_pkts_unchanged", int'(b_sent), 2);
        check("abort_back_idle", int'(b_state), 0);
        b_clr = 1'b1;
        @(posedge clock); #1;
        b_clr = 1'b0;
        @(negedge clock);
        check("err_clr_clears", int'(b_err), 0);

        // Reset in the middle of a drain.
        b_tx = 1'b1;
        @(posedge clock); #1;
        b_tx = 1'b0;
        @(posedge clock); #1;
        b_drain(500, dn, dat, wlow);
        check("mid_drain_no_done", dn, 0);
        c0 = b_clear_cnt; d0 = b_done_cnt;
        b_reset = 1'b1;
        #2;
        check("mid_reset_async_outputs",
              int'({b_state, b_wr, b_rd, b_load, b_err, b_sent}), 0);
        @(posedge clock); #1;
        b_reset = 1'b0;
        repeat (3) begin @(posedge clock); #1; end
        check("mid_reset_no_clear", b_clear_cnt - c0, 0);
        check("mid_reset_no_done", b_done_cnt - d0, 0);
        b_tx = 1'b1;
        @(posedge clock); #1;
        b_tx = 1'b0;
        @(posedge clock); #1;
        b_drain(B_P, dn, dat, wlow);
        check("post_reset_full_packet", dat, B_P);
        @(negedge clock);
        check("post_reset_pkts_sent", int'(b_sent), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
